// File: rtl/timebase_pkg.sv
// Shared constants and helpers for the timebase generator and its channels.
package timebase_pkg;

  localparam int unsigned CH_IDX_W = 4;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  // Clock cycles per base tick; callers guarantee an exact multiple >= 2.
  function automatic int unsigned calc_presc(input int unsigned clk_hz,
                                             input int unsigned base_hz);
    return clk_hz / base_hz;
  endfunction

endpackage

// File: rtl/timebase_channel.sv
// One timer channel: counts base ticks up to its period and emits a registered expiry pulse.
module timebase_channel
  import timebase_pkg::*;
#(
  parameter int unsigned CNT_W = 27
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             base_tick_i,
  input  logic             sync_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_period_i,
  input  logic             load_oneshot_i,
  output logic             tick_o,
  output logic             active_o
);

  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             active_q, active_d;
  logic             tick_q, tick_d;
  logic             expire;

  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    active_d = active_q;
    tick_d   = 1'b0;
    expire   = active_q && base_tick_i && (cnt_q == period_q - CNT_W'(1));

    // A load overrides both sync and a coincident expiry.
    if (load_i) begin
      period_d = load_period_i;
      mode_d   = load_oneshot_i;
      cnt_d    = '0;
      active_d = |load_period_i;
    end else if (sync_i) begin
      cnt_d = '0;
    end else if (expire) begin
      tick_d = 1'b1;
      cnt_d  = '0;
      if (mode_q == MODE_ONESHOT) begin
        active_d = 1'b0;
      end
    end else if (active_q && base_tick_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      period_q <= '0;
      cnt_q    <= '0;
      mode_q   <= MODE_PERIODIC;
      active_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      active_q <= active_d;
      tick_q   <= tick_d;
    end
  end

  assign tick_o   = tick_q;
  assign active_o = active_q;

endmodule

// File: rtl/timebase_gen.sv
// Free-running prescaler producing a shared base tick, driving NUM_CH timer channels.
// Define TIMEBASE_GEN_SYNC_EN to add a sync input that realigns the prescaler and counters.
module timebase_gen
  import timebase_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100000000,
  parameter int unsigned BASE_HZ = 1000000,
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 27
) (
  input  logic                clock,
  input  logic                reset,
`ifdef TIMEBASE_GEN_SYNC_EN
  input  logic                sync,
`endif
  input  logic                load_valid,
  input  logic [CH_IDX_W-1:0] load_ch,
  input  logic [CNT_W-1:0]    load_period,
  input  logic                load_oneshot,
  output logic                base_tick,
  output logic [NUM_CH-1:0]   tick,
  output logic [NUM_CH-1:0]   active
);

  localparam int unsigned PRESC = calc_presc(CLK_HZ, BASE_HZ);
  localparam int unsigned PW    = $clog2(PRESC);

  logic [PW-1:0] presc_q, presc_d;
  logic          sync_w;

`ifdef TIMEBASE_GEN_SYNC_EN
  assign sync_w = sync;
`else
  assign sync_w = 1'b0;
`endif

  always_comb begin
    base_tick = (presc_q == PW'(PRESC - 1));
    presc_d   = presc_q + PW'(1);
    if (sync_w || base_tick) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // Out-of-range channel indices match no instance and are dropped here.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic load_en;
    assign load_en = load_valid && (load_ch == CH_IDX_W'(i));

    timebase_channel #(
      .CNT_W (CNT_W)
    ) u_channel (
      .clock          (clock),
      .reset          (reset),
      .base_tick_i    (base_tick),
      .sync_i         (sync_w),
      .load_i         (load_en),
      .load_period_i  (load_period),
      .load_oneshot_i (load_oneshot),
      .tick_o         (tick[i]),
      .active_o       (active[i])
    );
  end

endmodule

// File: tb/tb_timebase_gen.sv
// Directed bench for timebase_gen with a queue of expected tick cycles per channel.
module tb_timebase_gen;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int PR  = 10;
  localparam int HOR = 3000;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          load_valid = 1'b0;
  logic [3:0]    load_ch = '0;
  logic [CW-1:0] load_period = '0;
  logic          load_oneshot = 1'b0;
`ifdef TIMEBASE_GEN_SYNC_EN
  logic          sync = 1'b0;
`endif
  logic           base_tick;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] active;

  typedef struct {
    int cyc;
    int ch;
    bit os;
  } exp_t;

  exp_t           q[$];
  int             cyc;
  int             ph;
  int             checks;
  int             errors;
  logic [NCH-1:0] exp_active;

  timebase_gen #(
    .CLK_HZ  (1000),
    .BASE_HZ (100),
    .NUM_CH  (NCH),
    .CNT_W   (CW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
`ifdef TIMEBASE_GEN_SYNC_EN
    .sync         (sync),
`endif
    .load_valid   (load_valid),
    .load_ch      (load_ch),
    .load_period  (load_period),
    .load_oneshot (load_oneshot),
    .base_tick    (base_tick),
    .tick         (tick),
    .active       (active)
  );

  always #5 clock = ~clock;

  function automatic int first_bt(input int from);
    return from + ((((ph + 9 - from) % PR) + PR) % PR);
  endfunction

  task automatic check();
    logic [NCH-1:0] exp_tick;
    logic           exp_bt;
    exp_tick = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        exp_tick[q[i].ch] = 1'b1;
        if (q[i].os) exp_active[q[i].ch] = 1'b0;
        q.delete(i);
      end
    end
    exp_bt = ((((cyc - ph) % PR) + PR) % PR) == 9;
    checks++;
    assert (base_tick === exp_bt) else begin
      errors++;
      $error("FAIL base_tick cyc=%0d got=%b exp=%b", cyc, base_tick, exp_bt);
    end
    checks++;
    assert (tick === exp_tick) else begin
      errors++;
      $error("FAIL tick cyc=%0d got=%b exp=%b", cyc, tick, exp_tick);
    end
    checks++;
    assert (active === exp_active) else begin
      errors++;
      $error("FAIL active cyc=%0d got=%b exp=%b", cyc, active, exp_active);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    check();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic load(input int ch, input int p, input bit os);
    int t;
    load_valid   = 1'b1;
    load_ch      = 4'(ch);
    load_period  = CW'(p);
    load_oneshot = os;
    if (ch < NCH) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].ch == ch && q[i].cyc > cyc) q.delete(i);
      end
      exp_active[ch] = (p != 0);
      if (p != 0) begin
        t = first_bt(cyc + 1) + (p - 1) * PR + 1;
        if (os) begin
          q.push_back('{cyc: t, ch: ch, os: 1'b1});
        end else begin
          while (t < HOR) begin
            q.push_back('{cyc: t, ch: ch, os: 1'b0});
            t += p * PR;
          end
        end
      end
    end
    step();
    load_valid   = 1'b0;
    load_ch      = '0;
    load_period  = '0;
    load_oneshot = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    checks++;
    assert ({base_tick, tick, active} === '0) else begin
      errors++;
      $error("FAIL %s got=%b exp=0", tag, {base_tick, tick, active});
    end
  endtask

  initial begin
    int t0;
    checks     = 0;
    errors     = 0;
    exp_active = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    cyc   = 0;
    ph    = 0;
    check();
    run(31);

    // Periodic ch0 with period 3, then a one-shot on ch2.
    load(0, 3, 1'b0);
    run(70);
    load(2, 2, 1'b1);
    run(220);

    // Reload ch0 in the base-tick cycle of its expiry.
    t0 = HOR;
    foreach (q[i]) if (q[i].ch == 0 && q[i].cyc < t0) t0 = q[i].cyc;
    while (cyc < t0 - 1) step();
    load(0, 5, 1'b0);
    run(120);
    load(0, 0, 1'b0);
    run(60);

    // Out-of-range index must leave ch1 untouched.
    load(1, 4, 1'b0);
    run(20);
    load(7, 4, 1'b0);
    run(60);

    load(0, 1, 1'b0);
    load(3, 2, 1'b0);
    run(40);

    // Reset mid-count.
    reset = 1'b1;
    #1;
    check_zero("reset_async");
    repeat (2) @(posedge clock);
    #1;
    check_zero("reset_hold");
    reset      = 1'b0;
    cyc        = 0;
    ph         = 0;
    q.delete();
    exp_active = '0;
    check();
    run(60);

`ifdef TIMEBASE_GEN_SYNC_EN
    run(5);
    sync = 1'b1;
    ph   = cyc + 1;
    load(1, 1, 1'b0);
    sync = 1'b0;
    run(40);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timebase_gen.md
TIMEBASE_GEN -- requirements
Module: timebase_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter BASE_HZ, default 1000000, meaning shared base-tick rate in Hz; CLK_HZ SHALL be an integer multiple of BASE_HZ, and the prescale ratio PRESC = CLK_HZ/BASE_HZ SHALL be >= 2.
REQ-003 SHALL have parameter NUM_CH, default 4, meaning number of independent timer channels (1..16).
REQ-004 SHALL have parameter CNT_W, default 27, meaning channel period/counter width in bits.
REQ-005 SHALL have port clock, input, 1, meaning system clock; reset is asynchronous and active-high, and the block is clocked by clock.
REQ-006 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-007 SHALL have port load_valid, input, 1, meaning a channel-program request is valid this cycle.
REQ-008 SHALL have port load_ch, input, 4, meaning target channel index.
REQ-009 SHALL have port load_period, input, CNT_W, meaning channel period in base ticks (0 = stop).
REQ-010 SHALL have port load_oneshot, input, 1, meaning 1 = one-shot mode, 0 = periodic mode.
REQ-011 SHALL have port base_tick, output, 1, meaning a one-cycle pulse at BASE_HZ.
REQ-012 SHALL have port tick, output, NUM_CH, meaning per-channel one-cycle expiry pulse.
REQ-013 SHALL have port active, output, NUM_CH, meaning the channel is armed and counting.

Function
REQ-014 Prescaler SHALL count 0..PRESC-1 and wrap to 0; base_tick SHALL be 1 exactly in cycles where the prescaler equals PRESC-1, giving a period of exactly PRESC cycles.
REQ-015 An active channel SHALL advance its counter only in base_tick cycles; in the base_tick cycle where counter == period-1, tick[i] SHALL be registered high for exactly the next clock cycle.
REQ-016 In periodic mode, counter SHALL wrap to 0 at expiry and active stays 1; tick period = period*PRESC cycles exactly.
REQ-017 In one-shot mode, active[i] SHALL clear in the same edge that sets tick[i]; no further ticks until reloaded.
REQ-018 Load SHALL be always accepted (no backpressure): load_valid with load_ch < NUM_CH SHALL, on that edge, store period and mode, clear the counter to 0, and set active = (load_period != 0).
REQ-019 load_ch >= NUM_CH SHALL be ignored with no state change.
REQ-020 Load coinciding with the expiry base_tick on the same channel: load SHALL win, with no tick and the counter cleared.
REQ-021 period = 1 SHALL produce a tick after every base_tick (periodic), i.e. every PRESC cycles.
REQ-022 The prescaler SHALL be free-running and unaffected by loads; first tick latency after load is therefore (period-1)*PRESC + prescaler residual + 1 cycles.
REQ-023 Counter arithmetic SHALL be unsigned CNT_W bits with no overflow possible (counter < period always).

Reset
REQ-024 On reset: prescaler, all counters, periods, modes = 0; base_tick, tick, active = 0; reset deassertion SHALL start the prescaler at 0.
REQ-025 Reset mid-count SHALL abort all channels; no tick SHALL be emitted on or after the reset edge until reloaded.

Configuration
REQ-026 Macro TIMEBASE_GEN_SYNC_EN, when defined, SHALL add input sync (1 bit): a sync pulse SHALL clear the prescaler and all active counters in the same edge, while a simultaneous load SHALL still take effect; without the macro the port SHALL be absent and the behaviour as above.

Structure
REQ-027 Shared package timebase_pkg SHALL hold the channel-index width constant (4), the mode encoding constants (PERIODIC = 0, ONESHOT = 1), and a function computing PRESC.
REQ-028 Per-channel counter/mode/tick logic SHALL be sub-module timebase_channel, instantiated NUM_CH times via generate; the prescaler stays in the top level.

Verification (CLK_HZ=1000, BASE_HZ=100, PRESC=10, NUM_CH=4, CNT_W=8)
REQ-029 Release reset, no loads -> base_tick high at cycles 9, 19, 29...; tick and active stay 0.
REQ-030 Load ch0 period=3 periodic -> active[0]=1; ticks spaced exactly 30 cycles apart, each 1 cycle wide.
REQ-031 Load ch2 period=2 one-shot -> exactly one tick[2]; active[2] clears on the same edge; no ticks for 200 further cycles.
REQ-032 Reload ch0 with period=5 in its expiry base_tick cycle -> no tick that cycle; next tick 50 cycles later; load period=0 -> active[0]=0 and no ticks.
REQ-033 load_ch=7 with period=4 -> no state change on any channel.
REQ-034 Assert reset mid-count on all channels -> all outputs 0 immediately; no ticks after release without reload; with TIMEBASE_GEN_SYNC_EN, a sync pulse realigns base_tick to 9 cycles after sync.
